// File: rtl/yin_period_search.sv
// YIN lag sweep: walks tau over a difference engine and reports the first lag whose CMND drops
// below threshold. Define YIN_LOCAL_MIN_EN to refine that hit to the following local minimum.
module yin_period_search #(
    parameter int unsigned MAX_TAU   = 40,
    parameter int unsigned MIN_TAU   = 2,
    parameter int unsigned ACC_WIDTH = 39,
    parameter int unsigned THR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [THR_WIDTH-1:0] threshold,
    input  logic                 diff_ready,
    input  logic [ACC_WIDTH-1:0] diff_value,
    output logic                 diff_reset,
    output logic [5:0]           diff_tau,
    output logic                 busy,
    output logic                 done,
    output logic                 voiced,
    output logic [5:0]           period
);
    localparam int unsigned SumWidth  = ACC_WIDTH + 6;
    localparam int unsigned ProdWidth = SumWidth + THR_WIDTH;
    localparam logic [5:0]  MaxTau    = 6'(MAX_TAU);
    localparam logic [5:0]  MinTau    = 6'(MIN_TAU);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StEval, StDone} state_t;

    state_t               state;
    logic [5:0]           tau;
    logic [SumWidth-1:0]  sum;
    logic [SumWidth-1:0]  sum_next;
    logic [ACC_WIDTH-1:0] d_cap;
    logic [THR_WIDTH-1:0] thr;
    logic [ProdWidth-1:0] lhs;
    logic [ProdWidth-1:0] rhs;
    logic                 hit;
    logic                 end_sweep;
    logic                 end_voiced;
    logic [5:0]           end_period;
`ifdef YIN_LOCAL_MIN_EN
    logic                 found;
    logic [5:0]           best;
    logic [ACC_WIDTH-1:0] d_best;
    logic                 take_best;
`endif

    // CMND test d*tau/S < thr/2^THR_WIDTH, cross-multiplied so no divider is needed.
    always_comb begin
        sum_next = sum + SumWidth'(d_cap);
        lhs      = (ProdWidth'(d_cap) * ProdWidth'(tau)) << THR_WIDTH;
        rhs      = ProdWidth'(thr) * ProdWidth'(sum_next);
        hit      = (tau >= MinTau) && (sum_next != '0) && (lhs < rhs);
`ifdef YIN_LOCAL_MIN_EN
        if (!found) begin
            take_best  = hit;
            end_sweep  = (tau == MaxTau);
            end_voiced = hit;
            end_period = hit ? tau : 6'd0;
        end else if (d_cap < d_best) begin
            take_best  = 1'b1;
            end_sweep  = (tau == MaxTau);
            end_voiced = 1'b1;
            end_period = tau;
        end else begin
            take_best  = 1'b0;
            end_sweep  = 1'b1;
            end_voiced = 1'b1;
            end_period = best;
        end
`else
        end_sweep  = hit || (tau == MaxTau);
        end_voiced = hit;
        end_period = hit ? tau : 6'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            tau        <= 6'd1;
            sum        <= '0;
            d_cap      <= '0;
            thr        <= '0;
            diff_reset <= 1'b1;
            diff_tau   <= 6'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            voiced     <= 1'b0;
            period     <= 6'd0;
`ifdef YIN_LOCAL_MIN_EN
            found      <= 1'b0;
            best       <= 6'd0;
            d_best     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        thr        <= threshold;
                        tau        <= 6'd1;
                        sum        <= '0;
                        diff_tau   <= 6'd1;
                        diff_reset <= 1'b1;
                        busy       <= 1'b1;
                        state      <= StIssue;
`ifdef YIN_LOCAL_MIN_EN
                        found      <= 1'b0;
`endif
                    end
                end
                StIssue: begin
                    diff_reset <= 1'b0;
                    state      <= StWait;
                end
                StWait: begin
                    if (diff_ready) begin
                        d_cap      <= diff_value;
                        diff_reset <= 1'b1;
                        state      <= StEval;
                    end
                end
                StEval: begin
                    sum <= sum_next;
                    if (end_sweep) begin
                        done   <= 1'b1;
                        voiced <= end_voiced;
                        period <= end_period;
                        state  <= StDone;
                    end else begin
                        tau      <= tau + 6'd1;
                        diff_tau <= tau + 6'd1;
                        state    <= StIssue;
                    end
`ifdef YIN_LOCAL_MIN_EN
                    if (take_best) begin
                        found  <= 1'b1;
                        best   <= tau;
                        d_best <= d_cap;
                    end
`endif
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/yin_period_search.md
YIN_PERIOD_SEARCH -- requirements
Module: yin_period_search

Interface
REQ-001 SHALL have parameter MAX_TAU, default 40, largest lag evaluated (6-bit lag domain).
REQ-002 SHALL have parameter MIN_TAU, default 2, smallest lag eligible as a period result.
REQ-003 SHALL have parameter ACC_WIDTH, default 39, width of the difference-function input.
REQ-004 SHALL have parameter THR_WIDTH, default 8, threshold width, unsigned Q0.THR_WIDTH.
REQ-005 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  begin one lag sweep; sampled only in IDLE.
REQ-008 SHALL have port threshold  input  THR_WIDTH  CMND threshold; captured at start.
REQ-009 SHALL have port diff_ready  input  1  difference engine finished current lag.
REQ-010 SHALL have port diff_value  input  ACC_WIDTH  d(tau) from difference engine.
REQ-011 SHALL have port diff_reset  output  1  restart difference engine.
REQ-012 SHALL have port diff_tau  output  6  lag presented to difference engine.
REQ-013 SHALL have port busy  output  1  sweep in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-015 SHALL have port voiced  output  1  period found below threshold.
REQ-016 SHALL have port period  output  6  detected lag; 0 when unvoiced.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> EVAL -> (ISSUE | DONE) -> IDLE.
REQ-018 IDLE: on start=1, latch threshold, tau=1, running sum S=0, go ISSUE; start ignored in all other states.
REQ-019 ISSUE: one cycle, diff_tau=tau, diff_reset=1, diff_ready ignored; go WAIT.
REQ-020 WAIT: diff_reset=0, diff_tau held; on diff_ready=1 capture diff_value as D, go EVAL.
REQ-021 diff_reset SHALL be 1 in IDLE, ISSUE, EVAL, DONE and 0 only in WAIT.
REQ-022 EVAL (one cycle): S=S+D, S width ACC_WIDTH+6, no overflow possible.
REQ-023 EVAL, tau>=MIN_TAU: hit when D*tau*2^THR_WIDTH < threshold*S (updated S), compared at full product width, no division.
REQ-024 S=0 (silence) SHALL evaluate as no hit.
REQ-025 First hit SHALL set voiced=1, period=tau, then go DONE (base mode, see REQ-033).
REQ-026 No hit and tau==MAX_TAU SHALL go DONE with voiced=0, period=0; else tau=tau+1, go ISSUE.
REQ-027 DONE: done=1 for exactly one cycle, go IDLE; voiced/period held until next done.
REQ-028 busy SHALL be 1 in ISSUE, WAIT, EVAL, DONE; 0 in IDLE.
REQ-029 start asserted in the DONE cycle SHALL be ignored; accepted from first IDLE cycle.

Reset
REQ-030 reset SHALL force IDLE from any state including mid-WAIT; tau=1, S=0, best-candidate registers cleared.
REQ-031 Reset values: diff_reset=1, diff_tau=0, busy=0, done=0, voiced=0, period=0.
REQ-032 reset and start high together SHALL leave block in IDLE, start discarded.

Configuration
REQ-033 Macro YIN_LOCAL_MIN_EN defined: after first hit, record best=tau, Dbest=D; keep sweeping; each next lag with D<Dbest updates best; first lag with D>=Dbest, or MAX_TAU, ends sweep with period=best, voiced=1.
REQ-034 Macro YIN_LOCAL_MIN_EN undefined: sweep ends at first hit per REQ-025; no best/Dbest registers synthesized.

Verification
REQ-035 Model d(tau)=1000 all lags, threshold=128 (0.5) -> CMND=1 everywhere, done after tau=40, voiced=0, period=0.
REQ-036 d=1000 except d(10)=50, threshold=38 -> hit at tau=10 (10*50*256=128000 < 38*9050=343900), voiced=1, period=10, base mode.
REQ-037 With YIN_LOCAL_MIN_EN, d(10)=50, d(11)=20, d(12)=30, others 1000, threshold=38 -> period=11, voiced=1, done one cycle.
REQ-038 All d=0 -> voiced=0, period=0 after MAX_TAU sweep.
REQ-039 reset pulsed during WAIT at tau=5 -> next cycle busy=0, diff_reset=1, done never asserted; subsequent start sweeps from tau=1.
REQ-040 start held high continuously -> back-to-back sweeps, exactly one done pulse per sweep, diff_ready held high during ISSUE never captured.
